// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch stage with a one-entry
//            buffer toward decode, branch redirect and memory-timeout halt.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  opcode,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int          CNT_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic               redirect_pend_q, redirect_pend_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fetch_err_q, fetch_err_d;

  logic [31:0]        target_al;
  logic [CNT_W-1:0]   wait_inc;
  logic               unused_target_lsbs;

  assign target_al          = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];
  assign wait_inc           = wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    if_instr_d      = if_instr_q;
    if_pc_d         = if_pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_pc_d   = redirect_pc_q;
    wait_cnt_d      = wait_cnt_q;
    fetch_err_d     = fetch_err_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        wait_cnt_d = '0;
        if (branch_taken) begin
          pc_d = target_al;
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          // Returned data belongs to a stale path whenever a redirect is live.
          wait_cnt_d = '0;
          if (branch_taken) begin
            pc_d            = target_al;
            redirect_pend_d = 1'b0;
          end else if (redirect_pend_q) begin
            pc_d            = redirect_pc_q;
            redirect_pend_d = 1'b0;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end else begin
          if (branch_taken) begin
            redirect_pend_d = 1'b1;
            redirect_pc_d   = target_al;
          end
          wait_cnt_d = wait_inc;
          if (wait_inc == CNT_W'(ACK_TIMEOUT)) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d            = target_al;
          redirect_pend_d = 1'b0;
          wait_cnt_d      = '0;
          state_d         = S_REQ;
        end else if (if_ready) begin
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC_AL;
      if_instr_q      <= '0;
      if_pc_q         <= '0;
      redirect_pend_q <= 1'b0;
      redirect_pc_q   <= '0;
      wait_cnt_q      <= '0;
      fetch_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      if_instr_q      <= if_instr_d;
      if_pc_q         <= if_pc_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_pc_q   <= redirect_pc_d;
      wait_cnt_q      <= wait_cnt_d;
      fetch_err_q     <= fetch_err_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == S_HOLD);
  assign if_instr  = if_instr_q;
  assign opcode    = if_instr_q[31:26];
  assign if_pc     = if_pc_q;
  assign fetch_err = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_ready;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        if_valid,  if_valid2;
  logic [31:0] if_instr,  if_instr2;
  logic [5:0]  opcode,    opcode2;
  logic [31:0] if_pc,     if_pc2;
  logic        fetch_err, fetch_err2;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .opcode(opcode), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  // Second instance shares all inputs; it exercises the pc wrap-around.
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(16)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid2), .if_ready(if_ready),
    .if_instr(if_instr2), .opcode(opcode2), .if_pc(if_pc2),
    .fetch_err(fetch_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},  32'd0);
    check({tag, "_valid"}, {31'd0, if_valid},  32'd0);
    check({tag, "_addr"},  imem_addr,          32'd0);
    check({tag, "_instr"}, if_instr,           32'd0);
    check({tag, "_opc"},   {26'd0, opcode},    32'd0);
    check({tag, "_ifpc"},  if_pc,              32'd0);
    check({tag, "_err"},   {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    if_ready      = 1'b0;
    tick(); tick(); tick();

    check_reset_outputs("rst");
    check("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);

    // Streaming with same-cycle ack: REQ/HOLD alternate.
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1000_0000;
    if_ready   = 1'b1;
    tick();
    check("first_req",      {31'd0, imem_req}, 32'd1);
    check("first_addr",     imem_addr,         32'h0);
    check("wrap_addr0",     imem_addr2,        32'hFFFF_FFFC);
    tick();
    check("hold0_valid",    {31'd0, if_valid}, 32'd1);
    check("hold0_pc",       if_pc,             32'h0);
    check("hold0_opcode",   {26'd0, opcode},   32'd4);
    check("hold0_instr",    if_instr,          32'h1000_0000);
    check("wrap_ifpc0",     if_pc2,            32'hFFFF_FFFC);
    tick();
    check("req1_addr",      imem_addr,         32'h4);
    check("req1_valid",     {31'd0, if_valid}, 32'd0);
    check("wrap_addr1",     imem_addr2,        32'h0);
    tick();
    check("hold1_pc",       if_pc,             32'h4);
    tick();
    check("req2_addr",      imem_addr,         32'h8);
    tick();
    check("hold2_pc",       if_pc,             32'h8);
    check("hold2_valid",    {31'd0, if_valid}, 32'd1);

    // Decode stalls for 5 cycles while new data would be available.
    if_ready   = 1'b0;
    imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_req",   {31'd0, imem_req}, 32'd0);
      check("stall_pc",    if_pc,             32'h8);
      check("stall_instr", if_instr,          32'h1000_0000);
    end
    if_ready = 1'b1;
    tick();
    check("unstall_req",  {31'd0, imem_req}, 32'd1);
    check("unstall_addr", imem_addr,         32'hC);

    // Reset mid-REQ with ack still high must abandon the fetch.
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreq_rst");

    rst_n      = 1'b1;
    imem_rdata = 32'h1000_0000;
    tick();   // REQ 0
    tick();   // HOLD 0
    tick();   // REQ 4
    tick();   // HOLD 4
    tick();   // REQ 8
    check("pre_redir_addr", imem_addr, 32'h8);

    // Delayed ack with a misaligned branch in the first wait cycle.
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
    check("redir_w1_addr", imem_addr,         32'h8);
    check("redir_w1_req",  {31'd0, imem_req}, 32'd1);
    tick();
    check("redir_w2_addr", imem_addr,         32'h8);
    tick();
    check("redir_w3_addr", imem_addr,         32'h8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("redir_drop_valid", {31'd0, if_valid}, 32'd0);
    check("redir_new_req",    {31'd0, imem_req}, 32'd1);
    check("redir_new_addr",   imem_addr,         32'h40);
    imem_rdata = 32'h0800_0001;
    tick();
    check("redir_hold_pc",    if_pc,    32'h40);
    check("redir_hold_instr", if_instr, 32'h0800_0001);
    check("redir_hold_opc",   {26'd0, opcode}, 32'd2);

    // Branch and if_ready together in HOLD: branch wins.
    if_ready      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    check("hb_valid", {31'd0, if_valid}, 32'd0);
    check("hb_req",   {31'd0, imem_req}, 32'd1);
    check("hb_addr",  imem_addr,         32'h100);
    tick();
    check("hb_hold_pc", if_pc, 32'h100);

    // Branch in IDLE, then ack never arrives.
    rst_n = 1'b0;
    tick();
    rst_n         = 1'b1;
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0203;
    tick();
    branch_taken = 1'b0;
    check("idle_br_addr", imem_addr,         32'h200);
    check("idle_br_req",  {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_req", {31'd0, imem_req},  32'd1);
      check("to_err", {31'd0, fetch_err}, 32'd0);
    end
    tick();
    check("halt_err",   {31'd0, fetch_err}, 32'd1);
    check("halt_req",   {31'd0, imem_req},  32'd0);
    check("halt_valid", {31'd0, if_valid},  32'd0);

    imem_ack      = 1'b1;
    if_ready      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0500;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_stay_err",  {31'd0, fetch_err}, 32'd1);
      check("halt_stay_req",  {31'd0, imem_req},  32'd0);
      check("halt_stay_addr", imem_addr,          32'h200);
    end
    branch_taken = 1'b0;
    imem_ack     = 1'b0;

    rst_n = 1'b0;
    tick();
    check_reset_outputs("halt_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
